// File: rtl/lsu_resp_queue_pkg.sv
// Shared access-width codes and per-request metadata for the LSU response queue.
package lsu_resp_queue_pkg;

    localparam logic [1:0] LSU_W_BYTE = 2'b00;
    localparam logic [1:0] LSU_W_HALF = 2'b01;
    localparam logic [1:0] LSU_W_WORD = 2'b10;

    typedef struct packed {
        logic       is_load;
        logic [1:0] addr_lo;
        logic [1:0] width;
        logic       is_unsigned;
    } lsu_meta_t;

endpackage

// File: rtl/lsu_resp_queue_load_align.sv
// Selects the addressed byte/half of a word-aligned read and sign- or zero-extends it.
module load_align
    import lsu_resp_queue_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  width,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        // Halfword loads are always 2-byte aligned, so only addr_lo[1] matters.
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];

        case (width)
            LSU_W_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            LSU_W_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:    result = data;
        endcase
    end

endmodule

// File: rtl/lsu_resp_queue.sv
// In-order tracker of dcache requests: captures responses, aligns load data and
// hands results to writeback in program order while throttling address generation.
module lsu_resp_queue
    import lsu_resp_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            req_fire,
    input  logic            req_is_load,
    input  logic [1:0]      req_addr_lo,
    input  logic [1:0]      req_width,
    input  logic            req_unsigned,
    input  logic [RD_W-1:0] req_rd,
    output logic            req_ready,
    input  logic            resp_valid,
    input  logic [31:0]     resp_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            kill;
        lsu_meta_t       meta;
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
    } entry_t;

    entry_t        q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] resp_ptr;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          presented;

    entry_t        head_e;
    logic          head_done;
    logic          show;
    logic          pop;
    logic          resp_take;
    logic [31:0]   aligned;

    assign head_e    = q[head];
    assign head_done = head_e.valid & head_e.done;
    // Once a result is on the bus it stays there, even if a flush kills it afterwards.
    assign show      = head_done & head_e.meta.is_load & (~head_e.kill | presented);
    assign pop       = head_done & (~show | wb_ready);
    assign resp_take = resp_valid & q[resp_ptr].valid & ~q[resp_ptr].done;
    assign req_ready = (count != (PW+1)'(DEPTH));

    load_align u_load_align (
        .data        (head_e.data),
        .addr_lo     (head_e.meta.addr_lo),
        .width       (head_e.meta.width),
        .is_unsigned (head_e.meta.is_unsigned),
        .result      (aligned)
    );

    assign wb_valid = show;
    assign wb_rd    = show ? head_e.rd : '0;
    assign wb_data  = show ? aligned : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head      <= '0;
            resp_ptr  <= '0;
            tail      <= '0;
            count     <= '0;
            presented <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++)
                    if (q[i].valid) q[i].kill <= 1'b1;
            end
            if (pop) begin
                q[head].valid <= 1'b0;
                head          <= head + 1'b1;
            end
            if (resp_take) begin
                q[resp_ptr].data <= resp_rdata;
                q[resp_ptr].done <= 1'b1;
                resp_ptr         <= resp_ptr + 1'b1;
            end
            // A request that arrives with a flush is allocated but born killed.
            if (req_fire) begin
                q[tail] <= '{valid: 1'b1, done: 1'b0, kill: flush,
                             meta: '{is_load: req_is_load, addr_lo: req_addr_lo,
                                     width: req_width, is_unsigned: req_unsigned},
                             rd: req_rd, data: '0};
                tail    <= tail + 1'b1;
            end
            case ({req_fire, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            presented <= show & ~wb_ready;
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            assert (!(req_fire && !req_ready));
            assert (!(resp_valid && !resp_take));
        end
    end

endmodule

// File: tb/tb_lsu_resp_queue.sv
// Directed and randomized checks of lsu_resp_queue against a program-order queue model.
module tb_lsu_resp_queue;

    localparam int DEPTH = 4;
    localparam int RD_W  = 5;

    logic            clk = 1'b0;
    logic            resetn;
    logic            flush;
    logic            req_fire;
    logic            req_is_load;
    logic [1:0]      req_addr_lo;
    logic [1:0]      req_width;
    logic            req_unsigned;
    logic [RD_W-1:0] req_rd;
    logic            req_ready;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit              is_load;
        logic [1:0]      a;
        logic [1:0]      w;
        bit              u;
        logic [RD_W-1:0] rd;
        bit              killed;
        bit              done;
        logic [31:0]     val;
    } ref_t;

    ref_t mq[$];
    ref_t ne;
    bit   pres;
    bit   exp_valid;
    bit   hv;
    bit   pop;

    always #5 clk = ~clk;

    lsu_resp_queue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .req_fire     (req_fire),
        .req_is_load  (req_is_load),
        .req_addr_lo  (req_addr_lo),
        .req_width    (req_width),
        .req_unsigned (req_unsigned),
        .req_rd       (req_rd),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    // Expected load value from plain arithmetic on the raw word.
    function automatic logic [31:0] ref_align(input logic [31:0] raw, input logic [1:0] a,
                                              input logic [1:0] w, input bit u);
        longint v;
        case (w)
            2'b00: begin
                v = longint'((raw >> (8 * a)) % 256);
                if (!u && v >= 128) v = v - 256;
            end
            2'b01: begin
                v = longint'((raw >> (8 * a)) % 65536);
                if (!u && v >= 32768) v = v - 65536;
            end
            default: v = longint'(raw);
        endcase
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit ld, input logic [1:0] a, input logic [1:0] w,
                             input bit u, input logic [RD_W-1:0] rd);
        req_fire     = 1'b1;
        req_is_load  = ld;
        req_addr_lo  = a;
        req_width    = w;
        req_unsigned = u;
        req_rd       = rd;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; req_fire = 1'b0; req_is_load = 1'b0;
        req_addr_lo = '0; req_width = '0; req_unsigned = 1'b0; req_rd = '0;
        resp_valid = 1'b0; resp_rdata = '0; wb_ready = 1'b0;
        step(); step();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_wb_rd", wb_rd, 0);
        chk("reset_wb_data", wb_data, 0);
        resetn = 1'b1;
        step();

        // Signed byte load at offset 1, one cycle of response-to-writeback latency.
        drive_req(1, 2'b01, 2'b00, 0, 5'd3);
        step();
        req_fire = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h1234_80FF;
        #1;
        chk("no_comb_resp_to_wb", wb_valid, 0);
        step();
        resp_valid = 1'b0;
        chk("byte_wb_valid", wb_valid, 1);
        chk("byte_wb_data", wb_data, 32'hFFFF_FF80);
        chk("byte_wb_rd", wb_rd, 3);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("byte_popped", wb_valid, 0);
        chk("byte_ready", req_ready, 1);

        // Upper halfword, zero- then sign-extended.
        for (int u = 1; u >= 0; u--) begin
            drive_req(1, 2'b10, 2'b01, bit'(u), 5'd7);
            step();
            req_fire = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h8001_0000;
            step();
            resp_valid = 1'b0;
            chk("half_wb_data", wb_data, (u == 1) ? 32'h0000_8001 : 32'hFFFF_8001);
            wb_ready = 1'b1;
            step();
            wb_ready = 1'b0;
        end

        // Fill to capacity without responses, then free one slot.
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", req_ready, 1);
            drive_req(1, 2'b00, 2'b10, 0, 5'(i + 1));
            step();
        end
        req_fire = 1'b0;
        chk("full_not_ready", req_ready, 0);
        resp_valid = 1'b1; resp_rdata = 32'h0000_00A0;
        step();
        resp_valid = 1'b0;
        chk("full_after_resp", req_ready, 0);
        chk("full_head_valid", wb_valid, 1);
        chk("full_head_rd", wb_rd, 1);
        wb_ready = 1'b1;
        step();
        chk("ready_after_pop", req_ready, 1);
        for (int i = 1; i < 4; i++) begin
            resp_valid = 1'b1; resp_rdata = 32'(i);
            step();
            resp_valid = 1'b0;
            chk("drain_valid", wb_valid, 1);
            chk("drain_rd", wb_rd, i + 1);
            chk("drain_data", wb_data, i);
            step();
        end
        wb_ready = 1'b0;

        // Load / store / load with writeback stalled for three cycles.
        drive_req(1, 2'b00, 2'b10, 0, 5'd10); step();
        drive_req(0, 2'b00, 2'b10, 0, 5'd0);  step();
        drive_req(1, 2'b00, 2'b10, 0, 5'd11); step();
        req_fire = 1'b0;
        resp_valid = 1'b1; resp_rdata = 32'h1111_1111;
        step();
        for (int k = 0; k < 3; k++) begin
            resp_valid = (k < 2);
            resp_rdata = (k == 0) ? 32'h2222_2222 : 32'h3333_3333;
            chk("stall_valid", wb_valid, 1);
            chk("stall_rd", wb_rd, 10);
            chk("stall_data", wb_data, 32'h1111_1111);
            step();
        end
        resp_valid = 1'b0;
        wb_ready = 1'b1;
        chk("stall_release_valid", wb_valid, 1);
        step();
        chk("store_silent", wb_valid, 0);
        step();
        chk("second_load_valid", wb_valid, 1);
        chk("second_load_rd", wb_rd, 11);
        chk("second_load_data", wb_data, 32'h3333_3333);
        step();
        chk("lsl_empty", wb_valid, 0);
        wb_ready = 1'b0;

        // Flush with three loads outstanding and a fourth arriving alongside it.
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 2'b00, 2'b10, 0, 5'(20 + i));
            step();
        end
        drive_req(1, 2'b00, 2'b10, 0, 5'd23);
        flush = 1'b1;
        step();
        req_fire = 1'b0; flush = 1'b0;
        chk("flush_full", req_ready, 0);
        wb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            resp_valid = (k < 4); resp_rdata = 32'hDEAD_0000 + 32'(k);
            chk("flushed_no_wb", wb_valid, 0);
            step();
        end
        resp_valid = 1'b0;
        chk("flush_ready_restored", req_ready, 1);
        drive_req(1, 2'b00, 2'b10, 0, 5'd9);
        step();
        req_fire = 1'b0; resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D;
        step();
        resp_valid = 1'b0;
        chk("post_flush_valid", wb_valid, 1);
        chk("post_flush_data", wb_data, 32'hCAFE_F00D);
        step();
        wb_ready = 1'b0;

        // Asynchronous reset while two completed loads are waiting.
        drive_req(1, 2'b00, 2'b10, 0, 5'd12); step();
        drive_req(1, 2'b00, 2'b10, 0, 5'd13); step();
        req_fire = 1'b0;
        resp_valid = 1'b1; resp_rdata = 32'h0000_0012; step();
        resp_valid = 1'b1; resp_rdata = 32'h0000_0013; step();
        resp_valid = 1'b0;
        chk("pre_reset_valid", wb_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_wb_valid", wb_valid, 0);
        chk("async_reset_wb_data", wb_data, 0);
        chk("async_reset_ready", req_ready, 1);
        step();
        resetn = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("post_reset_fill_ready", req_ready, 1);
            drive_req(1, 2'b00, 2'b10, 0, 5'(i));
            step();
        end
        req_fire = 1'b0;
        chk("post_reset_full", req_ready, 0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // Randomized traffic against the queue model, then a drain phase.
        mq.delete();
        pres = 1'b0;
        for (int c = 0; c < 500; c++) begin
            bit drain;
            drain = (c >= 400);
            flush = !drain && ($urandom_range(0, 19) == 0);
            req_fire = !drain && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            req_is_load = ($urandom_range(0, 3) != 0);
            req_width = 2'($urandom_range(0, 2));
            req_addr_lo = 2'($urandom_range(0, 3));
            if (req_width == 2'b01) req_addr_lo[0] = 1'b0;
            req_unsigned = 1'($urandom_range(0, 1));
            req_rd = RD_W'($urandom());
            resp_rdata = $urandom();
            resp_valid = 1'b0;
            foreach (mq[i]) if (!mq[i].done) resp_valid = ($urandom_range(0, 2) != 0);
            wb_ready = drain || ($urandom_range(0, 1) == 1);

            hv = (mq.size() > 0) && mq[0].done;
            exp_valid = hv && mq[0].is_load && (!mq[0].killed || pres);
            chk("rand_wb_valid", wb_valid, exp_valid);
            if (exp_valid) begin
                chk("rand_wb_rd", wb_rd, mq[0].rd);
                chk("rand_wb_data", wb_data, mq[0].val);
            end
            chk("rand_req_ready", req_ready, mq.size() != DEPTH);

            pop = hv && (!exp_valid || wb_ready);
            if (flush) foreach (mq[i]) mq[i].killed = 1'b1;
            if (resp_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].done) begin
                        mq[i].done = 1'b1;
                        mq[i].val = ref_align(resp_rdata, mq[i].a, mq[i].w, mq[i].u);
                        break;
                    end
                end
            end
            pres = exp_valid && !wb_ready;
            if (pop) void'(mq.pop_front());
            if (req_fire) begin
                ne.is_load = req_is_load; ne.a = req_addr_lo; ne.w = req_width;
                ne.u = req_unsigned; ne.rd = req_rd; ne.killed = flush;
                ne.done = 1'b0; ne.val = '0;
                mq.push_back(ne);
            end
            step();
        end
        req_fire = 1'b0; resp_valid = 1'b0; flush = 1'b0;
        chk("final_wb_valid", wb_valid, 0);
        chk("final_req_ready", req_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_resp_queue.md
Name: lsu_resp_queue

Overview:
In-order load/store response tracker between the data-cache interface and writeback; it sits directly downstream of the address-generation unit.
- Records metadata for every request the dcache accepts: address low bits, access width, signedness, destination register.
- Captures each dcache response, aligns and extends load data, and presents writebacks in program order with a valid/ready handshake.
- Throttles the address-generation unit so that no dcache response ever lacks a slot.

Parameters:
DEPTH, 4, entries in flight; power of two, at least 2
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; kills every outstanding entry
req_fire  in  1  dcache accepted a request this cycle (valid & ready)
req_is_load  in  1  1 = load, 0 = store
req_addr_lo  in  2  address bits [1:0]
req_width  in  2  00 byte, 01 half, 10 word
req_unsigned  in  1  zero-extend instead of sign-extend
req_rd  in  RD_W  destination register
req_ready  out  1  space is available; gates the address-generation unit's issue
resp_valid  in  1  one dcache response, returned in request order, cannot be stalled
resp_rdata  in  32  raw word-aligned read data (ignored for stores)
wb_valid  out  1  a load result is available
wb_ready  in  1  writeback accepts the result
wb_rd  out  RD_W  destination register
wb_data  out  32  aligned and extended load data

Behaviour:
- Reset (async, resetn=0): all entries invalid; head, resp_ptr and tail pointers = 0; count = 0; wb_valid=0; wb_rd=0; wb_data=0; req_ready=1. Reset mid-operation discards all state; late dcache responses after reset are the dcache's responsibility.
- Entry fields: valid, done, kill, is_load, addr_lo, width, unsigned, rd, data[31:0].
- Allocate: on req_fire, write the entry at tail with done=0 and kill=flush; then tail++ (wraps mod DEPTH).
- Flush priority: when flush and req_fire occur in the same cycle, the new entry is still allocated, but killed.
- Response capture: on resp_valid, the entry at resp_ptr gets data=resp_rdata and done=1; then resp_ptr++.
  - Stores set done in the same way.
  - resp_valid while no entry is pending (resp_ptr==tail with the slot invalid) is a protocol error: ignore it, flag it with an assertion.
- Flush: sets kill on every valid entry. Killed entries still occupy capacity until their response arrives.
- Retire at head (head valid & done):
  - is_load & ~kill: wb_valid=1. Pop on wb_ready.
  - store or killed: pop silently the next cycle; wb_valid=0.
- Latency: a response captured in cycle N drives wb_valid in cycle N+1 at the earliest. There is no combinational path from resp_* to wb_*.
- wb_rd and wb_data are combinational from head-entry registers, gated to 0 when wb_valid=0.
- Alignment:
  - byte: the byte at addr_lo from the data.
  - half: data[31:16] if addr_lo[1], else data[15:0]. addr_lo[0]=1 never occurs because misalignment is trapped upstream.
  - word: data as is; addr_lo ignored.
  - Extension: sign-extend when unsigned=0, otherwise zero-extend.
- Occupancy: count increments on alloc and decrements on pop; both in the same cycle leaves it unchanged. req_ready = (count != DEPTH), computed from the registered count.
  - req_fire with req_ready=0 is illegal; assert.
  - Full and empty are distinguished by count, not by the pointers.
- A wb_valid that is asserted stays asserted with stable wb_rd/wb_data until wb_ready, even when a flush arrives.
  - The kill applies to entries not yet presented.
  - A presented entry whose kill bit is set on a later cycle is still held; when popped it is dropped without being counted as a write.

Decomposition:
- Shared header (define.vh): width codes LSU_W_BYTE, LSU_W_HALF, LSU_W_WORD; macro LSU_ENTRY_WD for the packed entry width.
- Sub-module: load_align, purely combinational (data, addr_lo, width, unsigned -> 32-bit result). Instantiated once at the head; reusable by the load path.
- Pointers, count and the entry array stay in lsu_resp_queue.

Test Plan:
- Byte load, unsigned=0, addr_lo=01, rdata=0x1234_80FF -> one cycle after resp: wb_valid=1, wb_data=0xFFFF_FF80, wb_rd=req_rd.
- Half load, unsigned=1, addr_lo=10, rdata=0x8001_0000 -> wb_data=0x0000_8001; same access with unsigned=0 -> 0xFFFF_8001.
- Fill 4 requests with no response -> req_ready=0 after the 4th. One response and a pop with wb_ready=1 -> req_ready=1 the following cycle; wrap-around of tail/head verified over 10 requests.
- Load, store, load interleaved; wb_ready held 0 for 3 cycles -> wb_valid and data stable; store never raises wb_valid; the loads appear in order.
- 3 outstanding loads, flush alongside a 4th req_fire -> all 4 responses are consumed without any wb_valid, count returns to 0, and req_ready is restored.
- resetn pulsed low mid-stream with 2 entries done -> wb_valid=0 immediately (async), count=0, req_ready=1.
